if_prefetch_unit: RTL and testbench



---
 rtl/pipeline_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/if_prefetch_unit.sv | 136 +++++++++++++
 tb/tb_if_prefetch_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the RV32IM pipeline front-end.
//   XLEN          : datapath width (PC and instruction word)
//   NOP_INSTR     : canonical ADDI x0,x0,0 encoding
//   fetch_state_e : prefetch FSM states
//                   IDLE = may issue a request
//                   WAIT = one request outstanding
//                   DROP = outstanding response is stale and must be discarded
package pipeline_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {instruction, pc} pairs for the prefetch unit.
//   clk, reset   : clock, synchronous active-high reset
//   flush_i      : empties the queue; wins over push and pop
//   push_i       : write push_data_i at the tail
//   push_data_i  : entry to store
//   pop_i        : advance the head (caller guarantees the queue is non-empty)
//   head_o       : entry at the head (undefined contents when empty)
//   count_o      : occupancy, CNT_W bits so full and empty are distinct
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples values from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;  // idle, or push+pop cancel out
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; validity is tracked by
  // the pointers and count alone, which keeps the array a plain register file.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front-end: generates the fetch PC, talks to instruction
// memory over req/gnt/rvalid with a single request outstanding, and queues
// returned instructions for the ID stage.
//   clk, reset        : clock, synchronous active-high reset
//   redirect_valid/pc : EX-stage taken branch/jump; flushes queue and in-flight fetch
//   imem_req/addr     : fetch request and word-aligned address
//   imem_gnt          : request accepted this cycle
//   imem_rvalid/rdata : response strobe and returned instruction
//   out_valid/ready   : handshake towards IF_ID_reg (ready low = stall)
//   out_instr/pc      : head instruction and its PC (zero when empty)
//   out_pc_plus_4     : out_pc + 4
//   queue_count       : current queue occupancy
module if_prefetch_unit #(
  parameter int               XLEN     = pipeline_pkg::XLEN,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter int               CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [XLEN-1:0]  imem_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_instr,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_pc_plus_4,
  output logic [CNT_W-1:0] queue_count
);

  import pipeline_pkg::*;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
  localparam logic [CNT_W:0]  DEPTH_W = (CNT_W + 1)'(DEPTH);

  fetch_state_e      state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;          // next address to fetch
  logic [XLEN-1:0]   req_pc_q, req_pc_d;  // PC of the outstanding request
  logic              req;
  logic              push, pop;
  logic [2*XLEN-1:0] fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    pending;
  logic              space;
  logic [XLEN-1:0]   redirect_target;
  logic              unused_redirect_lsbs;

  assign redirect_target      = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // An outstanding request already owns a slot, so a queue that is full
  // (counting in-flight data) can never be overrun by a response.
  assign pending = {1'b0, fifo_count} + {{CNT_W{1'b0}}, (state_q == WAIT)};
  assign space   = pending < DEPTH_W;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    req      = 1'b0;
    push     = 1'b0;

    case (state_q)
      IDLE: begin
        req = space && !redirect_valid;
        if (req && imem_gnt) begin
          state_d  = WAIT;
          req_pc_d = pc_q;
          pc_d     = pc_q + PC_STEP;  // wraps modulo 2^XLEN
        end
      end
      WAIT: begin
        if (imem_rvalid && !redirect_valid) begin
          push    = 1'b1;
          state_d = IDLE;
        end else if (redirect_valid && !imem_rvalid) begin
          state_d = DROP;  // response still owed, but it is now stale
        end else if (redirect_valid && imem_rvalid) begin
          state_d = IDLE;  // stale response arrives with the redirect; drop it
        end
      end
      DROP: begin
        if (imem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Redirect overrides the sequential PC in every state.
    if (redirect_valid) pc_d = redirect_target;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  fetch_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .push_data_i ({imem_rdata, req_pc_q}),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count)
  );

  // Outputs are forced quiet while reset is asserted, not only after it.
  assign imem_req      = req && !reset;
  assign imem_addr     = pc_q;
  assign out_valid     = (fifo_count != '0) && !reset;
  assign queue_count   = reset ? '0 : fifo_count;
  assign pop           = out_valid && out_ready && !redirect_valid;
  assign out_instr     = out_valid ? fifo_head[2*XLEN-1:XLEN] : '0;
  assign out_pc        = out_valid ? fifo_head[XLEN-1:0] : '0;
  assign out_pc_plus_4 = out_pc + PC_STEP;

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit: a per-cycle table of memory/ID-side
// inputs with hand-derived expected outputs, plus hand-written reset and
// PC-wrap sequences.
module tb_if_prefetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus_4;
  logic [2:0]  queue_count;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_valid;
  logic [31:0] w_instr, w_pc, w_pc4;
  logic [2:0]  w_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  if_prefetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus_4  (out_pc_plus_4),
    .queue_count    (queue_count)
  );

  // Second instance exercising PC wrap from the top of the address space.
  if_prefetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .imem_req       (w_req),
    .imem_addr      (w_addr),
    .imem_gnt       (1'b1),
    .imem_rvalid    (1'b0),
    .imem_rdata     (32'h0),
    .out_valid      (w_valid),
    .out_ready      (1'b0),
    .out_instr      (w_instr),
    .out_pc         (w_pc),
    .out_pc_plus_4  (w_pc4),
    .queue_count    (w_count)
  );

  typedef struct {
    logic        rv;     // redirect_valid
    logic [31:0] rpc;    // redirect_pc
    logic        gnt;
    logic        rvl;    // imem_rvalid
    logic [31:0] raddr;  // address whose memory word is returned
    logic        rdy;    // out_ready
    logic        req;    // expected imem_req
    logic [31:0] addr;   // expected imem_addr
    logic        ov;     // expected out_valid
    logic [31:0] opc;    // expected out_pc
    int          cnt;    // expected queue_count
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, 16'h0013};
  endfunction

  task automatic add(input logic rv, input logic [31:0] rpc, input logic gnt,
                     input logic rvl, input logic [31:0] raddr, input logic rdy,
                     input logic req, input logic [31:0] addr, input logic ov,
                     input logic [31:0] opc, input int cnt);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.gnt = gnt; v.rvl = rvl; v.raddr = raddr; v.rdy = rdy;
    v.req = req; v.addr = addr; v.ov = ov; v.opc = opc; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    out_ready      = 1'b0;
  endtask

  initial begin
    //  rv  rpc        gnt rvl raddr     rdy | req addr       ov opc        cnt
    // Streaming: gnt=1, rvalid one cycle after gnt, ready=1.
    add(0, 32'h0,     1, 0, 32'h0,   1,   1, 32'h000, 0, 32'h000, 0); // c0
    add(0, 32'h0,     1, 1, 32'h0,   1,   0, 32'h004, 0, 32'h000, 0);
    add(0, 32'h0,     1, 0, 32'h0,   1,   1, 32'h004, 1, 32'h000, 1);
    add(0, 32'h0,     1, 1, 32'h4,   1,   0, 32'h008, 0, 32'h000, 0);
    add(0, 32'h0,     1, 0, 32'h0,   1,   1, 32'h008, 1, 32'h004, 1);
    // Stall: ready=0 until the queue saturates.
    add(0, 32'h0,     1, 1, 32'h8,   0,   0, 32'h00C, 0, 32'h000, 0); // c5
    add(0, 32'h0,     1, 0, 32'h0,   0,   1, 32'h00C, 1, 32'h008, 1);
    add(0, 32'h0,     1, 1, 32'hC,   0,   0, 32'h010, 1, 32'h008, 1);
    add(0, 32'h0,     1, 0, 32'h0,   0,   1, 32'h010, 1, 32'h008, 2);
    add(0, 32'h0,     1, 1, 32'h10,  0,   0, 32'h014, 1, 32'h008, 2);
    add(0, 32'h0,     1, 0, 32'h0,   0,   1, 32'h014, 1, 32'h008, 3); // c10
    add(0, 32'h0,     1, 1, 32'h14,  0,   0, 32'h018, 1, 32'h008, 3);
    add(0, 32'h0,     1, 0, 32'h0,   0,   0, 32'h018, 1, 32'h008, 4); // full
    add(0, 32'h0,     1, 0, 32'h0,   0,   0, 32'h018, 1, 32'h008, 4);
    add(0, 32'h0,     1, 0, 32'h0,   0,   0, 32'h018, 1, 32'h008, 4);
    // Drain in order; gnt withheld once to check the address is held.
    add(0, 32'h0,     1, 0, 32'h0,   1,   0, 32'h018, 1, 32'h008, 4); // c15
    add(0, 32'h0,     0, 0, 32'h0,   1,   1, 32'h018, 1, 32'h00C, 3);
    add(0, 32'h0,     1, 0, 32'h0,   1,   1, 32'h018, 1, 32'h010, 2);
    add(0, 32'h0,     1, 0, 32'h0,   1,   0, 32'h01C, 1, 32'h014, 1);
    add(0, 32'h0,     1, 1, 32'h18,  1,   0, 32'h01C, 0, 32'h000, 0);
    add(0, 32'h0,     0, 0, 32'h0,   1,   1, 32'h01C, 1, 32'h018, 1); // c20
    // Redirect to 0x100 while WAIT, response delayed -> DROP.
    add(0, 32'h0,     1, 0, 32'h0,   1,   1, 32'h01C, 0, 32'h000, 0);
    add(1, 32'h100,   1, 0, 32'h0,   1,   0, 32'h020, 0, 32'h000, 0);
    add(0, 32'h0,     1, 0, 32'h0,   1,   0, 32'h100, 0, 32'h000, 0);
    add(0, 32'h0,     1, 0, 32'h0,   1,   0, 32'h100, 0, 32'h000, 0);
    add(0, 32'h0,     1, 1, 32'h1C,  1,   0, 32'h100, 0, 32'h000, 0); // c25 stale
    add(0, 32'h0,     1, 0, 32'h0,   1,   1, 32'h100, 0, 32'h000, 0);
    add(0, 32'h0,     1, 1, 32'h100, 1,   0, 32'h104, 0, 32'h000, 0);
    // Two queued, then redirect (unaligned 0x203) together with rvalid.
    add(0, 32'h0,     1, 0, 32'h0,   0,   1, 32'h104, 1, 32'h100, 1);
    add(0, 32'h0,     1, 1, 32'h104, 0,   0, 32'h108, 1, 32'h100, 1);
    add(0, 32'h0,     1, 0, 32'h0,   0,   1, 32'h108, 1, 32'h100, 2); // c30
    add(1, 32'h203,   1, 1, 32'h108, 1,   0, 32'h10C, 1, 32'h100, 2);
    add(0, 32'h0,     0, 0, 32'h0,   1,   1, 32'h200, 0, 32'h000, 0);
    add(0, 32'h0,     1, 0, 32'h0,   1,   1, 32'h200, 0, 32'h000, 0);
    add(0, 32'h0,     1, 1, 32'h200, 1,   0, 32'h204, 0, 32'h000, 0);
    add(0, 32'h0,     0, 0, 32'h0,   0,   1, 32'h204, 1, 32'h200, 1); // c35
    // Redirect in IDLE: request masked combinationally.
    add(1, 32'h300,   1, 0, 32'h0,   1,   0, 32'h204, 1, 32'h200, 1);
    add(0, 32'h0,     1, 0, 32'h0,   0,   1, 32'h300, 0, 32'h000, 0);
    add(0, 32'h0,     1, 1, 32'h300, 0,   0, 32'h304, 0, 32'h000, 0);
    add(0, 32'h0,     1, 0, 32'h0,   0,   1, 32'h304, 1, 32'h300, 1);
    add(0, 32'h0,     1, 1, 32'h304, 0,   0, 32'h308, 1, 32'h300, 1); // c40
    add(0, 32'h0,     1, 0, 32'h0,   0,   1, 32'h308, 1, 32'h300, 2);
    add(0, 32'h0,     1, 1, 32'h308, 0,   0, 32'h30C, 1, 32'h300, 2);
    add(0, 32'h0,     1, 0, 32'h0,   0,   1, 32'h30C, 1, 32'h300, 3); // -> WAIT, 3 queued

    // Reset phase.
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst req",   {31'b0, imem_req}, 32'h0);
    check("rst valid", {31'b0, out_valid}, 32'h0);
    check("rst count", {29'b0, queue_count}, 32'h0);
    check("rst addr",  imem_addr, 32'h0);
    check("rst instr", out_instr, 32'h0);
    check("wrap rst addr", w_addr, 32'hFFFF_FFFC);

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      @(negedge clk);
      reset          = 1'b0;
      redirect_valid = v.rv;
      redirect_pc    = v.rpc;
      imem_gnt       = v.gnt;
      imem_rvalid    = v.rvl;
      imem_rdata     = v.rvl ? mem_word(v.raddr) : 32'hDEAD_BEEF;
      out_ready      = v.rdy;
      #1;
      check($sformatf("v%0d req", i),   {31'b0, imem_req}, {31'b0, v.req});
      check($sformatf("v%0d addr", i),  imem_addr, v.addr);
      check($sformatf("v%0d valid", i), {31'b0, out_valid}, {31'b0, v.ov});
      check($sformatf("v%0d pc", i),    out_pc, v.opc);
      check($sformatf("v%0d pc4", i),   out_pc_plus_4, v.opc + 32'd4);
      check($sformatf("v%0d instr", i), out_instr, v.ov ? mem_word(v.opc) : 32'h0);
      check($sformatf("v%0d count", i), {29'b0, queue_count}, v.cnt);
      if (i == 0) begin
        check("wrap first addr", w_addr, 32'hFFFF_FFFC);
        check("wrap first req",  {31'b0, w_req}, 32'h1);
      end
      if (i == 1) check("wrap second addr", w_addr, 32'h0);
    end

    // Reset asserted while WAIT with 3 entries queued.
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    #1;
    check("midrst req",   {31'b0, imem_req}, 32'h0);
    check("midrst valid", {31'b0, out_valid}, 32'h0);
    check("midrst count", {29'b0, queue_count}, 32'h0);
    @(negedge clk);
    reset       = 1'b0;
    imem_rvalid = 1'b1;  // stray late response
    imem_rdata  = 32'hBAD0_0013;
    #1;
    check("postrst valid", {31'b0, out_valid}, 32'h0);
    check("postrst count", {29'b0, queue_count}, 32'h0);
    check("postrst addr",  imem_addr, 32'h0);
    check("postrst req",   {31'b0, imem_req}, 32'h1);
    @(negedge clk);
    imem_rvalid = 1'b0;
    #1;
    check("stray valid", {31'b0, out_valid}, 32'h0);
    check("stray count", {29'b0, queue_count}, 32'h0);
    check("stray addr",  imem_addr, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
